uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive front end. Oversamples the serial line, detects start bits, reassembles the data byte LSB-first and samples the parity bit. It drives the byte and the one-hot parity-bit flags directly into the receive parity checker (o_data -> i_datain, o_zerodetected/o_onedetected -> same-named inputs). It also reports framing (stop-bit) errors and signals frame completion to the receive buffer.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; even, >= 8; mid = OVERSAMPLE/2
DATA_BITS, 8, data bits per frame; must stay 8 while feeding the 8-bit parity checker
PARITY_EN, 1, 1 = frame carries a parity bit after the data bits; 0 = no parity bit

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_baud_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate
i_rx  input  1  asynchronous serial line, idle high
o_data  output  DATA_BITS  last received byte, held until next o_done
o_zerodetected  output  1  parity bit of last frame sampled as 0
o_onedetected  output  1  parity bit of last frame sampled as 1
o_stoperror  output  1  stop bit of last frame sampled as 0
o_done  output  1  one-cycle pulse: frame complete, outputs valid
o_busy  output  1  high in any state except IDLE

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high on i_rst. All state is updated only on rising i_clk.
- Reset values: o_data=0, o_zerodetected=0, o_onedetected=0, o_stoperror=0, o_done=0, o_busy=0, state=IDLE, counters=0, synchronizer flops=1.
- i_rx passes through a 2-flop synchronizer. All references to "rx" below mean the synchronized value.
- Tick counter tcnt has width $clog2(OVERSAMPLE). It advances only on cycles with i_baud_tick=1 and wraps OVERSAMPLE-1 -> 0.
- Bit sampling per bit period:
  - rx is captured at tcnt = mid-1, mid and mid+1.
  - The voted bit is the majority of the 3 samples. It is available at the tick where tcnt = mid+1 (the "decision tick").
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on the first cycle with rx=0, go to START and clear tcnt. i_baud_tick is not required for this transition.
  - START: at the decision tick, a voted 1 is a false start: return to IDLE with no o_done and no output change. At the tick where tcnt = OVERSAMPLE-1, go to DATA with bit counter = 0.
  - DATA: at each decision tick, shift the voted bit into the shift register LSB-first. At the end of bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: the voted bit is latched into a pending flag. At end of bit, go to STOP.
  - STOP: at the decision tick, in a single edge:
    - o_data <= shift register;
    - o_onedetected <= pending parity bit, o_zerodetected <= its inverse (both 0 when PARITY_EN=0);
    - o_stoperror <= ~voted bit;
    - o_done <= 1 for exactly one cycle;
    - state <= IDLE.
  - Returning to IDLE mid-stop-bit lets a start bit that follows immediately be caught.
- The three data/flag outputs change only on the o_done edge. They are stable between o_done pulses, so the parity checker's result is valid from the cycle o_done is high onward.
- o_zerodetected and o_onedetected are never both 1.
- When i_baud_tick stays low, all state holds.
- A stop-bit error still delivers data and o_done. Deciding whether to discard the frame is the consumer's job.
- Assertion of i_rst mid-frame aborts the frame: no o_done, and all outputs return to reset values on the next edge.
- Latency: o_done rises 1 cycle after the stop-bit decision tick. Counted from the start-bit falling edge this is about (1 + DATA_BITS + PARITY_EN) x OVERSAMPLE + mid + 1 ticks, plus 2-3 synchronizer cycles.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - default OVERSAMPLE=16 and DATA_BITS=8;
  - the localparam MID = OVERSAMPLE/2.
- One natural sub-module, uart_bit_sampler. It owns the tick counter, the 3-point capture and the majority vote, and outputs o_decide (decision-tick strobe), o_bitend (tcnt wrap strobe) and o_bit. It takes a clear input from the FSM.

Test Plan:
- Frame 0xA5, parity 0, stop 1, OVERSAMPLE=16 -> one o_done pulse; o_data=0xA5, o_zerodetected=1, o_onedetected=0, o_stoperror=0; o_busy falls with o_done.
- Frame 0x01 sent with parity bit 0 -> o_data=0x01, o_zerodetected=1. The downstream parity checker raises its error (parity of 0x01 is 1).
- rx low for 4 ticks only, then high -> false start; no o_done; o_busy returns to 0 within mid+2 ticks; outputs unchanged from the previous frame.
- Frame 0x3C with stop bit 0 -> o_data=0x3C, o_stoperror=1, o_done pulses once. The next clean frame 0xFF clears o_stoperror to 0 and sets o_onedetected=0, o_zerodetected=1.
- i_rst pulsed during data bit 4 of frame 0x5A -> all outputs 0, no o_done. The following frame 0xC3 is received correctly.
- Frame 0x96 with the tcnt=mid sample of bit 3 inverted (1 of 3 vote samples) -> o_data=0x96; frames sent back-to-back with zero idle between stop and next start -> both received, two o_done pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// frame geometry and the 2-of-3 vote used by the bit sampler.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int MID            = DEF_OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Majority of three samples; a single corrupted sample cannot flip the bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit timing for the UART receiver. Counts baud ticks within a bit
// period, captures the line around the bit centre and produces a
// majority-voted bit together with decision and end-of-bit strobes.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_baud_tick,
  input  logic i_clear,
  input  logic i_rx,
  output logic o_decide,
  output logic o_bitend,
  output logic o_bit
);

  localparam int CW         = $clog2(OVERSAMPLE);
  localparam int SAMPLE_MID = OVERSAMPLE / 2;

  localparam logic [CW-1:0] T_LO   = CW'(SAMPLE_MID - 1);
  localparam logic [CW-1:0] T_MID  = CW'(SAMPLE_MID);
  localparam logic [CW-1:0] T_HI   = CW'(SAMPLE_MID + 1);
  localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tcnt;
  logic          s_lo;
  logic          s_mid;

  // Tick counter: advances once per baud tick, held at zero while cleared.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    if (i_rst || i_clear) begin
      tcnt <= '0;
    end else if (i_baud_tick) begin
      tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
    end
  end

  // Capture the two early vote samples; the third is the live line value
  // on the decision tick itself.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (i_baud_tick) begin
      if (tcnt == T_LO)  s_lo  <= i_rx;
      if (tcnt == T_MID) s_mid <= i_rx;
    end
  end

  assign o_decide = i_baud_tick && !i_clear && (tcnt == T_HI);
  assign o_bitend = i_baud_tick && !i_clear && (tcnt == T_LAST);
  assign o_bit    = majority3(s_lo, s_mid, i_rx);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes the serial line, detects start
// bits, shifts in the data byte LSB-first, samples the parity bit and
// checks the stop bit. Results are published together with a one-cycle
// o_done pulse and held stable until the next frame completes.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_zerodetected,
  output logic                 o_onedetected,
  output logic                 o_stoperror,
  output logic                 o_done,
  output logic                 o_busy
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_e            state;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pending;

  logic                 clear;
  logic                 decide;
  logic                 bitend;
  logic                 bit_v;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // The tick counter is parked at zero while idle so a start edge always
  // begins a fresh bit period.
  assign clear  = (state == ST_IDLE);
  assign o_busy = (state != ST_IDLE);

  uart_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_baud_tick(i_baud_tick),
    .i_clear    (clear),
    .i_rx       (rx_sync),
    .o_decide   (decide),
    .o_bitend   (bitend),
    .o_bit      (bit_v)
  );

  // Frame FSM: walks start, data, optional parity and stop bits and
  // publishes the frame results on the stop-bit decision tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_pending    <= 1'b0;
      o_data         <= '0;
      o_zerodetected <= 1'b0;
      o_onedetected  <= 1'b0;
      o_stoperror    <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      // NOTE: o_done defaults low every cycle so it can only ever be a
      // single-cycle pulse; the STOP branch overrides it for one edge.
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state       <= ST_START;
            bit_cnt     <= '0;
            par_pending <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && bit_v) begin
            // Line went back high before the centre: glitch, not a start.
            state <= ST_IDLE;
          end else if (bitend) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {bit_v, shreg[DATA_BITS-1:1]};
          end
          if (bitend) begin
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            par_pending <= bit_v;
          end
          if (bitend) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave mid-stop-bit so a start bit immediately following the
          // stop bit is still seen from its falling edge.
          if (decide) begin
            o_data         <= shreg;
            o_onedetected  <= (PARITY_EN != 0) ? par_pending  : 1'b0;
            o_zerodetected <= (PARITY_EN != 0) ? ~par_pending : 1'b0;
            o_stoperror    <= ~bit_v;
            o_done         <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer. The serial line is built as
// a waveform of one value per baud tick; the expected frame is derived from
// that waveform by voting the three centre ticks of each bit.
module tb_uart_rx_deserializer;

  localparam int OS    = 16;
  localparam int NBITS = 11;  // start + 8 data + parity + stop

  logic       clk;
  logic       i_rst;
  logic       i_baud_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_zerodetected;
  logic       o_onedetected;
  logic       o_stoperror;
  logic       o_done;
  logic       o_busy;

  uart_rx_deserializer #(
    .OVERSAMPLE(OS),
    .DATA_BITS (8),
    .PARITY_EN (1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_baud_tick   (i_baud_tick),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_zerodetected(o_zerodetected),
    .o_onedetected (o_onedetected),
    .o_stoperror   (o_stoperror),
    .o_done        (o_done),
    .o_busy        (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       one;
    logic       se;
    logic       busy;
  } done_rec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gb;    // frame bit to glitch (-1: none)
    int         gs;    // tick within that bit
    int         gap;   // idle ticks after the frame
    logic [7:0] exp_data;
    logic       exp_zero;
    logic       exp_one;
    logic       exp_se;
  } frame_vec_t;

  int         checks;
  int         errors;
  int         done_cnt;
  done_rec_t  done_q[$];
  logic       wave[$];
  logic       tick_jitter;
  logic [7:0] last_data;
  logic       last_zero;
  logic       last_one;
  logic       last_se;
  frame_vec_t vecs[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick generator: one-cycle strobe every 4 cycles, optionally with
  // random extra gaps so the receiver must hold state between ticks.
  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    i_baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (wait_cnt == 0) begin
        i_baud_tick = 1'b1;
        wait_cnt    = 3;
        if (tick_jitter && ($urandom_range(0, 3) == 0)) wait_cnt += $urandom_range(1, 12);
      end else begin
        i_baud_tick = 1'b0;
        wait_cnt--;
      end
    end
  end

  // Done monitor: records the published outputs on every o_done cycle.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        done_q.push_back('{o_data, o_zerodetected, o_onedetected, o_stoperror, o_busy});
        done_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the line at v for one baud tick; returns 1 time unit after the tick edge.
  task automatic drive_seg(input logic v);
    int n;
    i_rx = v;
    n    = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!i_baud_tick && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no baud tick, expected one within 200 cycles");
    end
    #1;
  endtask

  task automatic build_frame(input logic [7:0] d, input logic p, input logic s,
                             input int gb, input int gs);
    logic v;
    wave.delete();
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (b == 9) v = p;
      else             v = s;
      for (int k = 0; k < OS; k++) wave.push_back(v);
    end
    if (gb >= 0) wave[gb*OS+gs] = ~wave[gb*OS+gs];
  endtask

  task automatic send_wave(input int gap);
    foreach (wave[k]) drive_seg(wave[k]);
    repeat (gap) drive_seg(1'b1);
  endtask

  // Reference: each bit is the 2-of-3 vote of the centre ticks of its period.
  function automatic logic vote_bit(input int b);
    int ones;
    ones = 0;
    for (int k = OS/2 - 1; k <= OS/2 + 1; k++) ones += (wave[b*OS+k] ? 1 : 0);
    return (ones >= 2);
  endfunction

  task automatic check_frame(input string tag, input int base, input logic [7:0] ed,
                             input logic ez, input logic eo, input logic es);
    done_rec_t r;
    check({tag, ".done_count"}, done_cnt - base, 1);
    if (done_q.size() != 0) begin
      r = done_q[$];
      done_q.delete();
      check({tag, ".data"},   r.data, ed);
      check({tag, ".zero"},   r.zero, ez);
      check({tag, ".one"},    r.one,  eo);
      check({tag, ".stoperr"}, r.se,  es);
      check({tag, ".busy_at_done"}, r.busy, 0);
      check({tag, ".flags_exclusive"}, r.zero & r.one, 0);
    end
    last_data = ed;
    last_zero = ez;
    last_one  = eo;
    last_se   = es;
  endtask

  initial begin
    int base;
    logic [7:0] d;
    logic [7:0] ed;
    logic p, s;
    int gb, gs, nb, ns, gap;

    checks      = 0;
    errors      = 0;
    tick_jitter = 1'b0;
    i_rx        = 1'b1;
    i_rst       = 1'b1;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, -1, 0, 4,  8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, -1, 0, 4,  8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, -1, 0, 28, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, -1, 0, 4,  8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h96, 1'b1, 1'b1, 4,  8, 0,  8'h96, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5B, 1'b0, 1'b1, -1, 0, 0,  8'h5B, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h24, 1'b1, 1'b1, 2,  7, 4,  8'h24, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset.data",    o_data, 0);
    check("reset.zero",    o_zerodetected, 0);
    check("reset.one",     o_onedetected, 0);
    check("reset.stoperr", o_stoperror, 0);
    check("reset.done",    o_done, 0);
    check("reset.busy",    o_busy, 0);
    i_rst = 1'b0;
    repeat (4) drive_seg(1'b1);

    // Directed frames
    for (int i = 0; i < 7; i++) begin
      base = done_cnt;
      build_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].gb, vecs[i].gs);
      send_wave(vecs[i].gap);
      check_frame($sformatf("vec%0d", i), base, vecs[i].exp_data,
                  vecs[i].exp_zero, vecs[i].exp_one, vecs[i].exp_se);
    end

    // False start: line low for 4 ticks only
    repeat (8) drive_seg(1'b1);
    base = done_cnt;
    repeat (4) drive_seg(1'b0);
    check("false_start.busy_high", o_busy, 1);
    repeat (OS/2 + 2) drive_seg(1'b1);
    check("false_start.busy_low", o_busy, 0);
    check("false_start.no_done", done_cnt - base, 0);
    check("false_start.data", o_data, last_data);
    check("false_start.zero", o_zerodetected, last_zero);
    check("false_start.one",  o_onedetected, last_one);
    check("false_start.stoperr", o_stoperror, last_se);

    // Reset during data bit 4 of 0x5A, then a clean 0xC3
    repeat (4) drive_seg(1'b1);
    base = done_cnt;
    build_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    for (int k = 0; k < 5*OS + 5; k++) drive_seg(wave[k]);
    check("abort.busy_before", o_busy, 1);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("abort.data",    o_data, 0);
    check("abort.zero",    o_zerodetected, 0);
    check("abort.one",     o_onedetected, 0);
    check("abort.stoperr", o_stoperror, 0);
    check("abort.busy",    o_busy, 0);
    repeat (3*OS) drive_seg(1'b1);
    check("abort.no_done", done_cnt - base, 0);
    check("abort.busy_idle", o_busy, 0);
    base = done_cnt;
    build_frame(8'hC3, 1'b0, 1'b1, -1, 0);
    send_wave(4);
    check_frame("after_abort", base, 8'hC3, 1'b1, 1'b0, 1'b0);

    // Randomized frames with tick jitter, glitches and back-to-back spacing
    tick_jitter = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) != 0);
      gb = int'($urandom_range(0, 9));
      gs = int'($urandom_range(OS/2 - 1, OS/2 + 1));
      build_frame(d, p, s, gb, gs);
      nb = int'($urandom_range(1, 9));
      ns = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 5)) : int'($urandom_range(12, 14));
      wave[nb*OS+ns] = ~wave[nb*OS+ns];
      for (int b = 0; b < 8; b++) ed[b] = vote_bit(b + 1);
      gap  = s ? int'($urandom_range(0, 3)) : int'($urandom_range(24, 30));
      base = done_cnt;
      send_wave(gap);
      check_frame($sformatf("rand%0d", i), base, ed, ~vote_bit(9), vote_bit(9), ~vote_bit(10));
    end
    tick_jitter = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
